bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all address ports.
REQ-002 Parameter: DATA_W, default 32, width of all data ports.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 mN_rreq  in  1  (N=0,1) read request from master N; held until mN_acc is seen.
REQ-007 mN_wreq  in  1  write request from master N; held until mN_acc is seen.
REQ-008 mN_addr  in  ADDR_W  master N address; valid from the cycle after mN_acc first seen high.
REQ-009 mN_wdata  in  DATA_W  master N write data; valid with mN_addr.
REQ-010 mN_acc  out  1  grant/accept to master N.
REQ-011 mN_busy  out  1  low for exactly one cycle when mN_rdata is valid; high otherwise.
REQ-012 mN_rdata  out  DATA_W  read data to master N.
REQ-013 mem_rd  out  1  read command to memory; held until mem_ready.
REQ-014 mem_wr  out  1  write command to memory; held until mem_ready.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: registered command payload.
REQ-016 mem_rdata  in  DATA_W  read data, valid when mem_ready=1.
REQ-017 mem_ready  in  1  one-cycle completion pulse, one per command.

Function
REQ-018 States: IDLE, GRANT, ADDR, MEM, DONE; one transaction in flight at a time.
REQ-019 IDLE: any request pending -> pick winner, set its acc=1, latch op (rreq wins over wreq on the same master), -> GRANT.
REQ-020 Arbitration: round-robin; with both masters requesting, grant the master not granted last; single requester is granted immediately.
REQ-021 GRANT (acc visible one cycle): read -> acc<=0; write -> acc held 1; -> ADDR.
REQ-022 ADDR: sample winner's addr (and wdata for writes) into mem_addr/mem_wdata, assert mem_rd or mem_wr, -> MEM.
REQ-023 MEM: hold command and payload stable until mem_ready; then deassert command; read: mN_rdata<=mem_rdata, mN_busy<=0; write: mN_acc<=0; -> DONE.
REQ-024 DONE: mN_busy<=1, update last-granted pointer, -> IDLE; minimum request-to-request turnaround is 5 cycles plus memory latency.
REQ-025 Loser's request is ignored until IDLE; never lost while held.
REQ-026 Non-granted master's acc stays 0 and busy stays 1 at all times.
REQ-027 mN_rdata holds its last value until the next read completes for that master.
REQ-028 mem_ready outside MEM is ignored.

Reset
REQ-029 Reset forces IDLE, m0_acc=m1_acc=0, m0_busy=m1_busy=1, mem_rd=mem_wr=0, last-granted pointer=1 (master 0 wins first tie).
REQ-030 Reset mid-transaction aborts it at once: the command drops the next cycle, and no data or acc pulse is delivered.
REQ-031 mem_addr, mem_wdata, and mN_rdata are not reset.

Structure
REQ-032 Shared package holds the state encoding, the master index constants (M_IFETCH=0, M_DATA=1) and the op encoding (OP_RD, OP_WR).
REQ-033 One sub-module arb_rr2: a combinational 2-way round-robin picker (inputs req[1:0], last; output grant index and valid).

Verification
REQ-034 Single read: m0_rreq with addr 0x80000010, mem_ready 3 cycles after mem_rd, mem_rdata 0xDEADBEEF -> mem_addr=0x80000010, m0_busy low one cycle with m0_rdata=0xDEADBEEF.
REQ-035 Single write: m1_wreq with addr 0x1FD003F8, wdata 0x41 -> mem_wr with that payload, m1_acc high from GRANT until the cycle after mem_ready.
REQ-036 Contention: m0 and m1 read every cycle -> grants alternate 0,1,0,1 starting with 0; no starvation over 100 transactions.
REQ-037 Same-master rreq+wreq asserted together -> read served first, then write.
REQ-038 Reset asserted in MEM -> mem_rd low the next cycle, no busy-low pulse, and the next request is served normally.
REQ-039 mem_ready held 0 for 50 cycles -> command and payload stable, the other master's acc stays 0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM states,
// master indices and the latched operation type.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        ADDR  = 3'd2,
        MEM   = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam logic M_IFETCH = 1'b0;
    localparam logic M_DATA   = 1'b1;

    // A master raising both strobes gets its read first; the write stays pending.
    function automatic op_t pick_op(input logic rreq);
        return rreq ? OP_RD : OP_WR;
    endfunction

endpackage

// File: rtl/bus_arbiter_arb_rr2.sv
// Combinational two-way round-robin picker: on a tie the master that was
// not granted last wins; a lone requester wins outright.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        grant = 1'b0;
        valid = |req;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of a single-command memory port. One
// transaction in flight: pick, grant, issue command, wait for mem_ready, retire.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_rreq,
    input  logic              m0_wreq,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_acc,
    output logic              m0_busy,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_rreq,
    input  logic              m1_wreq,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_acc,
    output logic              m1_busy,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_t            state;
    op_t               op;
    logic              sel;
    logic              last;
    logic [1:0]        acc_q;
    logic [1:0]        busy_q;
    logic [1:0]        rreq;
    logic [1:0]        any_req;
    logic              pick;
    logic              pick_valid;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    assign rreq    = {m1_rreq, m0_rreq};
    assign any_req = {m1_rreq | m1_wreq, m0_rreq | m0_wreq};

    assign m0_acc  = acc_q[0];
    assign m1_acc  = acc_q[1];
    assign m0_busy = busy_q[0];
    assign m1_busy = busy_q[1];

    assign addr_mux  = (sel == M_DATA) ? m1_addr  : m0_addr;
    assign wdata_mux = (sel == M_DATA) ? m1_wdata : m0_wdata;

    arb_rr2 u_pick (
        .req   (any_req),
        .last  (last),
        .grant (pick),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op     <= OP_RD;
            sel    <= M_IFETCH;
            last   <= M_DATA;
            acc_q  <= 2'b00;
            busy_q <= 2'b11;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        sel         <= pick;
                        op          <= pick_op(rreq[pick]);
                        acc_q[pick] <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    // Reads see a one-cycle accept; writes keep acc up until memory completes.
                    if (op == OP_RD) begin
                        acc_q[sel] <= 1'b0;
                    end
                    state <= ADDR;
                end
                ADDR: begin
                    mem_rd <= (op == OP_RD);
                    mem_wr <= (op == OP_WR);
                    state  <= MEM;
                end
                MEM: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (op == OP_RD) begin
                            busy_q[sel] <= 1'b0;
                        end else begin
                            acc_q[sel] <= 1'b0;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 2'b11;
                    last   <= sel;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: payload and read-data registers carry no reset; only the control above must come up defined.
    always_ff @(posedge clk) begin
        if (!reset && state == ADDR) begin
            mem_addr <= addr_mux;
            if (op == OP_WR) begin
                mem_wdata <= wdata_mux;
            end
        end
        // Gated by reset so an aborted read never lands in the master's data register.
        if (!reset && state == MEM && mem_ready && op == OP_RD) begin
            if (sel == M_DATA) begin
                m1_rdata <= mem_rdata;
            end else begin
                m0_rdata <= mem_rdata;
            end
        end
    end

endmodule
